// File: rtl/sound_mem_arbiter_if.sv
// rtl/sound_mem_arbiter_if.sv - request, completion and SDRAM client signals of the sound memory arbiter
//
// Groups every non-clock/reset signal of sound_mem_arbiter.
//   slave  modport : the arbiter (takes GLU/DOC requests and SDRAM responses,
//                    drives completions, SDRAM strobes and status flags)
//   master modport : the surrounding GLU/DOC logic plus SDRAM port model
// Signals: wr_req_i/wr_addr_i/wr_data_i/wr_byte_en_i/wr_done_o (GLU write path),
//          rd_req_i/rd_addr_i/rd_ready_o/rd_q_o (DOC read path),
//          mem_rd_o/mem_wr_o/mem_addr_o/mem_data_o/mem_byte_en_o/mem_ready_i/mem_q_i (SDRAM),
//          wr_overrun_o/timeout_o (sticky status).
interface sound_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 21
);
    logic                  wr_req_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [31:0]           wr_data_i;
    logic [3:0]            wr_byte_en_i;
    logic                  wr_done_o;

    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_ready_o;
    logic [31:0]           rd_q_o;

    logic                  mem_rd_o;
    logic                  mem_wr_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_data_o;
    logic [3:0]            mem_byte_en_o;
    logic                  mem_ready_i;
    logic [31:0]           mem_q_i;

    logic                  wr_overrun_o;
    logic                  timeout_o;

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, wr_byte_en_i,
        output wr_done_o,
        input  rd_req_i, rd_addr_i,
        output rd_ready_o, rd_q_o,
        output mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o,
        input  mem_ready_i, mem_q_i,
        output wr_overrun_o, timeout_o
    );

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, wr_byte_en_i,
        input  wr_done_o,
        output rd_req_i, rd_addr_i,
        input  rd_ready_o, rd_q_o,
        input  mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o,
        output mem_ready_i, mem_q_i,
        input  wr_overrun_o, timeout_o
    );
endinterface

// File: rtl/sound_mem_arbiter.sv
// rtl/sound_mem_arbiter.sv - shares one SDRAM client port between the GLU write path and DOC5503 reads
//
// Ports:
//   clk_logic    : system logic clock
//   system_reset : asynchronous, active-high reset
//   bus          : sound_mem_arbiter_if.slave (requests, completions, SDRAM client, status)
// Single-cycle request strobes are held in one-deep pending slots (write slot
// drops on overflow, read slot keeps the latest address), one access is issued
// at a time from separate in-flight registers, and a one-cycle done/ready pulse
// follows each SDRAM completion.
// Optional feature macro: SOUND_ARB_TIMEOUT_EN (watchdog abort after TIMEOUT_CYCLES).
module sound_mem_arbiter #(
    parameter int ADDR_WIDTH      = 21,
    parameter int READ_PRIORITY   = 1,
    parameter int WR_STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input logic                 clk_logic,
    input logic                 system_reset,
    sound_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(WR_STARVE_LIMIT);

    state_t                state;

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;

    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic [3:0]            starve_cnt;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;
    logic [3:0]            mem_be;
    logic                  rd_ready;
    logic [31:0]           rd_q;
    logic                  wr_done;
    logic                  wr_overrun;

`ifdef SOUND_ARB_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0]            tmo_cnt;
    logic                  tmo_flag;
`endif

    logic grant_rd;
    logic grant_wr;

    // Arbitration is only evaluated in IDLE; a grant frees its slot this cycle,
    // which is what lets a same-cycle request land in the freed slot.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE) begin
            if (wr_valid && rd_valid) begin
                if (READ_PRIORITY != 0 && starve_cnt != STARVE_LIM)
                    grant_rd = 1'b1;
                else
                    grant_wr = 1'b1;
            end else if (wr_valid) begin
                grant_wr = 1'b1;
            end else if (rd_valid) begin
                grant_rd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_logic or posedge system_reset) begin
        if (system_reset) begin
            state      <= IDLE;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            starve_cnt <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_be     <= '0;
            rd_ready   <= 1'b0;
            rd_q       <= '0;
            wr_done    <= 1'b0;
            wr_overrun <= 1'b0;
`ifdef SOUND_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            tmo_flag   <= 1'b0;
`endif
        end else begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            rd_ready <= 1'b0;
            wr_done  <= 1'b0;

            // Write slot: never overwritten while occupied, so an overflow is lost.
            if (bus.wr_req_i) begin
                if (!wr_valid || grant_wr) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= bus.wr_addr_i;
                    wr_data  <= bus.wr_data_i;
                    wr_be    <= bus.wr_byte_en_i;
                end else begin
                    wr_overrun <= 1'b1;
                end
            end else if (grant_wr) begin
                wr_valid <= 1'b0;
            end

            // Read slot: the DOC only cares about its newest address.
            if (bus.rd_req_i) begin
                rd_valid <= 1'b1;
                rd_addr  <= bus.rd_addr_i;
            end else if (grant_rd) begin
                rd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        mem_addr <= rd_addr;
                        mem_data <= '0;
                        mem_be   <= 4'b1111;
                        mem_rd   <= 1'b1;
                        state    <= RD_BUSY;
                        if (wr_valid && starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 4'd1;
`ifdef SOUND_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end else if (grant_wr) begin
                        mem_addr   <= wr_addr;
                        mem_data   <= wr_data;
                        mem_be     <= wr_be;
                        mem_wr     <= 1'b1;
                        state      <= WR_BUSY;
                        starve_cnt <= '0;
`ifdef SOUND_ARB_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                RD_BUSY: begin
                    if (bus.mem_ready_i) begin
                        rd_q     <= bus.mem_q_i;
                        rd_ready <= 1'b1;
                        state    <= IDLE;
                    end
`ifdef SOUND_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        rd_q     <= '0;
                        rd_ready <= 1'b1;
                        tmo_flag <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
`endif
                end
                WR_BUSY: begin
                    if (bus.mem_ready_i) begin
                        wr_done <= 1'b1;
                        state   <= IDLE;
                    end
`ifdef SOUND_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        wr_done  <= 1'b1;
                        tmo_flag <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_o      = mem_rd;
    assign bus.mem_wr_o      = mem_wr;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_data_o    = mem_data;
    assign bus.mem_byte_en_o = mem_be;
    assign bus.rd_ready_o    = rd_ready;
    assign bus.rd_q_o        = rd_q;
    assign bus.wr_done_o     = wr_done;
    assign bus.wr_overrun_o  = wr_overrun;
`ifdef SOUND_ARB_TIMEOUT_EN
    assign bus.timeout_o     = tmo_flag;
`else
    // No watchdog: the flag is constant 0 for any legal TIMEOUT_CYCLES (1..1023),
    // written against the parameter so it stays referenced in this build.
    assign bus.timeout_o     = (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: doc/sound_mem_arbiter.md
Name: sound_mem_arbiter

Overview:
- Shares one SDRAM client port between two sound requesters.
- Requesters: the GLU sound-RAM write path (CPU writes via $C03D) and the DOC5503 wavetable read path.
- Captures single-cycle request strobes into one-deep pending slots, arbitrates, issues one access at a time, and returns completion pulses.
- Sits between the GLU/DOC logic and a single sdram_port_if client, so the sound subsystem needs only one SDRAM port.

Parameters:
- ADDR_WIDTH, 21, word address width on all address ports.
- READ_PRIORITY, 1, 1 = DOC reads win simultaneous contention; 0 = writes win.
- WR_STARVE_LIMIT, 4, consecutive granted reads with a write pending before the write is forced next (READ_PRIORITY=1 only); range 1..15.
- TIMEOUT_CYCLES, 1023, watchdog limit in clk_logic cycles (optional feature only); range 1..1023.

Ports:
- clk_logic  in  1  system logic clock
- system_reset  in  1  asynchronous, active-high reset
- wr_req_i  in  1  GLU write strobe, one cycle
- wr_addr_i  in  ADDR_WIDTH  write word address
- wr_data_i  in  32  write data
- wr_byte_en_i  in  4  write byte lanes
- wr_done_o  out  1  write-complete pulse
- rd_req_i  in  1  DOC read strobe, one cycle
- rd_addr_i  in  ADDR_WIDTH  read word address
- rd_ready_o  out  1  read-data-valid pulse
- rd_q_o  out  32  read data, held until next rd_ready_o
- mem_rd_o  out  1  SDRAM read strobe
- mem_wr_o  out  1  SDRAM write strobe
- mem_addr_o  out  ADDR_WIDTH  SDRAM address
- mem_data_o  out  32  SDRAM write data
- mem_byte_en_o  out  4  SDRAM byte enables; 4'b1111 for reads
- mem_ready_i  in  1  SDRAM completion pulse
- mem_q_i  in  32  SDRAM read data, valid with mem_ready_i
- wr_overrun_o  out  1  sticky: a write was dropped
- timeout_o  out  1  sticky: a watchdog abort occurred

Behaviour:
- Reset values: all outputs 0 (mem_byte_en_o = 0, rd_q_o = 0), both pending slots empty, state IDLE, starve counter 0, sticky flags 0.
- Pending capture, write (wr_req_i):
  - Slot empty: latch addr/data/byte_en; slot valid next cycle.
  - Slot full and not being issued this cycle: drop the new request and set wr_overrun_o.
- Pending capture, read (rd_req_i):
  - Slot empty: latch addr.
  - Slot full: replace addr (latest wins); only one rd_ready_o results.
- A request arriving in the same cycle its slot is issued is captured into the freed slot. The in-flight access uses separate registers.
- State machine: IDLE, RD_BUSY, WR_BUSY.
  - IDLE, any slot valid: select a slot, move it to the in-flight registers, clear the slot, pulse mem_rd_o or mem_wr_o for exactly one cycle, go to RD_BUSY or WR_BUSY.
  - Issue latency: request in cycle 0, slot valid in cycle 1, strobe high in cycle 2.
  - mem_addr_o, mem_data_o and mem_byte_en_o are driven from in-flight registers and stay stable until completion.
  - RD_BUSY, mem_ready_i: next cycle rd_q_o = mem_q_i and rd_ready_o = 1 for one cycle; return to IDLE. Earliest next strobe is one cycle after that.
  - WR_BUSY, mem_ready_i: next cycle wr_done_o = 1 for one cycle; return to IDLE.
  - mem_ready_i in IDLE is ignored.
- Arbitration, both slots valid in IDLE:
  - READ_PRIORITY=1: read wins unless starve counter == WR_STARVE_LIMIT, in which case the write wins.
  - Starve counter increments per read granted while the write slot is valid; it clears when a write is issued.
  - READ_PRIORITY=0: write always wins; starve counter unused.
- Reset mid-access: immediate return to IDLE. Slots and in-flight registers are cleared, no done/ready pulse is generated, and SDRAM strobes drop asynchronously.

Optional Feature:
- Macro: SOUND_ARB_TIMEOUT_EN.
- With the macro:
  - A 10-bit counter runs in RD_BUSY/WR_BUSY and clears on issue.
  - If it reaches TIMEOUT_CYCLES without mem_ready_i, the access aborts and the state returns to IDLE.
  - Aborted read: rd_ready_o pulses with rd_q_o = 0. Aborted write: wr_done_o pulses.
  - timeout_o is set and stays set until reset.
  - A late mem_ready_i arriving afterwards in IDLE is ignored.
- Without the macro: no counter; the block waits indefinitely; timeout_o is tied 0.

Test Plan:
- Read sequencing: rd_req_i, addr 0x10005, idle arbiter -> mem_rd_o pulses in cycle 2 with mem_addr_o = 0x10005. mem_ready_i with mem_q_i = 0xA1B2C3D4 -> rd_ready_o one cycle later with rd_q_o = 0xA1B2C3D4.
- Simultaneous requests, READ_PRIORITY=1: rd_req_i and wr_req_i in the same cycle -> read issued first, write issued after the read completes, wr_done_o after the write's mem_ready_i.
- Write starvation: write pending plus 6 back-to-back reads, WR_STARVE_LIMIT=4 -> exactly 4 reads, then the write, then the remaining reads.
- Overrun: two wr_req_i while the write slot is full and a read is in flight -> second write dropped, wr_overrun_o = 1, only one mem_wr_o observed with the first write's data.
- Timeout (SOUND_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): read issued, mem_ready_i never asserted -> rd_ready_o with rd_q_o = 0 after 8 cycles, timeout_o = 1. A later mem_ready_i is ignored and the next queued write proceeds.
- Reset mid-access: system_reset asserted during WR_BUSY -> all outputs 0 immediately. After release, no wr_done_o and no new strobe until a fresh request.
